// File: rtl/usb_conv2x2_stream_pkg.sv
// Shared definitions for the 2x2 box-sum streaming stage: FSM encoding,
// default geometry and a small address-width helper.
package usb_conv2x2_stream_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_COLS   = 16;
    localparam int DEF_COL_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/usb_conv2x2_stream_line_buf.sv
// Single line buffer holding the previous row: asynchronous read, synchronous
// write, no reset (contents are always rewritten by the first row of a frame).
module conv_line_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read returns the old word when a write to the same address is pending.
    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/usb_conv2x2_stream.sv
// Streaming 2x2 all-ones convolution over a raster frame of up to MAX_COLS
// columns; one result per window, registered output with valid/ready.
module usb_conv2x2_stream
    import usb_conv2x2_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_COLS   = DEF_MAX_COLS,
    parameter int COL_W      = DEF_COL_W
) (
    input  logic                  i_usb_ifclk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [COL_W-1:0]      i_cols,
    input  logic [COL_W-1:0]      i_rows,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int AW = addrWidth(MAX_COLS);
    localparam logic [COL_W-1:0] MAX_COLS_C = COL_W'(MAX_COLS);
    localparam logic [COL_W-1:0] ONE_C      = COL_W'(1);
    localparam logic [COL_W-1:0] TWO_C      = COL_W'(2);

    state_e                state_q, state_d;
    logic [COL_W-1:0]      cols_q, cols_d;
    logic [COL_W-1:0]      rows_q, rows_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [COL_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] topPrev_q, topPrev_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  outValid_q, outValid_d;
    logic                  err_q, err_d;

    logic                  inReady;
    logic                  outHs;
    logic                  startOk;
    logic                  lbWe;
    logic                  loadResult;
    logic [DATA_WIDTH-1:0] topCur;
    logic [AW-1:0]         lbAddr;

    assign lbAddr = AW'(col_q);

    conv_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_COLS),
        .AW         (AW)
    ) u_line_buf (
        .clk_i   (i_usb_ifclk),
        .we_i    (lbWe),
        .waddr_i (lbAddr),
        .wdata_i (i_in_data),
        .raddr_i (lbAddr),
        .rdata_o (topCur)
    );

    always_comb begin
        state_d    = state_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        col_d      = col_q;
        row_d      = row_q;
        left_d     = left_q;
        topPrev_d  = topPrev_q;
        result_d   = result_q;
        err_d      = 1'b0;
        inReady    = 1'b0;
        lbWe       = 1'b0;
        loadResult = 1'b0;
        outHs      = outValid_q && i_out_ready;
        startOk    = (i_cols >= TWO_C) && (i_cols <= MAX_COLS_C) && (i_rows >= TWO_C);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (startOk) begin
                        state_d = ST_FILL;
                        cols_d  = i_cols;
                        rows_d  = i_rows;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                inReady = 1'b1;
                if (i_in_valid) begin
                    lbWe = 1'b1;
                    if (col_q == cols_q - ONE_C) begin
                        col_d   = '0;
                        row_d   = ONE_C;
                        state_d = ST_RUN;
                    end else begin
                        col_d = col_q + ONE_C;
                    end
                end
            end
            ST_RUN: begin
                // Accept only when the output register is free or draining this edge.
                inReady = !outValid_q || i_out_ready;
                if (inReady && i_in_valid) begin
                    lbWe      = 1'b1;
                    topPrev_d = topCur;
                    left_d    = i_in_data;
                    if (col_q != '0) begin
                        loadResult = 1'b1;
                        result_d   = topPrev_q + topCur + left_q + i_in_data;
                    end
                    if (col_q == cols_q - ONE_C) begin
                        col_d = '0;
                        if (row_q == rows_q - ONE_C) begin
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + ONE_C;
                        end
                    end else begin
                        col_d = col_q + ONE_C;
                    end
                end
            end
            ST_DRAIN: begin
                if (outHs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        outValid_d = loadResult ? 1'b1 : (outHs ? 1'b0 : outValid_q);
    end

    always_ff @(posedge i_usb_ifclk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            left_q     <= '0;
            topPrev_q  <= '0;
            result_q   <= '0;
            outValid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            left_q     <= left_d;
            topPrev_q  <= topPrev_d;
            result_q   <= result_d;
            outValid_q <= outValid_d;
            err_q      <= err_d;
        end
    end

    assign o_in_ready  = inReady;
    assign o_out_valid = outValid_q;
    assign o_out_data  = result_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_err       = err_q;

endmodule

// File: tb/tb_usb_conv2x2_stream.sv
// Directed self-checking bench for usb_conv2x2_stream: hand-computed window
// sums, backpressure, wrap-around, start rejection and mid-frame reset.
module tb_usb_conv2x2_stream;

    localparam int DW   = 16;
    localparam int CW   = 5;
    localparam int MAXC = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [CW-1:0] cols;
    logic [CW-1:0] rows;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          inReady;
    logic          outValid;
    logic [DW-1:0] outData;
    logic          outReady;
    logic          busy;
    logic          done;
    logic          err;

    int testsRun = 0;
    int testsFailed = 0;
    int pixQ[$];
    int expQ[$];

    always #5 clk = ~clk;

    usb_conv2x2_stream #(
        .DATA_WIDTH (DW),
        .MAX_COLS   (MAXC),
        .COL_W      (CW)
    ) dut (
        .i_usb_ifclk (clk),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_cols      (cols),
        .i_rows      (rows),
        .i_in_valid  (inValid),
        .i_in_data   (inData),
        .o_in_ready  (inReady),
        .o_out_valid (outValid),
        .o_out_data  (outData),
        .i_out_ready (outReady),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " in_ready"}, {31'd0, inReady}, 32'd0);
        checkOutput({tag, " out_valid"}, {31'd0, outValid}, 32'd0);
        checkOutput({tag, " out_data"}, {16'd0, outData}, 32'd0);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " err"}, {31'd0, err}, 32'd0);
    endtask

    // Pulse a start that must be rejected and confirm the single-cycle error.
    task automatic checkReject(input int c, input int r);
        @(negedge clk);
        start = 1'b1;
        cols  = CW'(c);
        rows  = CW'(r);
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput($sformatf("reject C=%0d R=%0d err", c, r), {31'd0, err}, 32'd1);
        checkOutput($sformatf("reject C=%0d R=%0d busy", c, r), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("reject C=%0d R=%0d in_ready", c, r), {31'd0, inReady}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput($sformatf("reject C=%0d R=%0d err clears", c, r), {31'd0, err}, 32'd0);
    endtask

    // Stream pixQ as one frame and score results against expQ.
    task automatic applyStimulus(input string name, input int c, input int r,
                                 input bit toggleReady, input int abortAfter, input bit pokeStart);
        int  pixIdx = 0;
        int  resCnt = 0;
        int  cyc = 0;
        int  errSeen = 0;
        bit  finished = 1'b0;
        bit  rdyPhase = 1'b1;
        bit  inAcc;
        bit  outHs;

        @(negedge clk);
        start = 1'b1;
        cols  = CW'(c);
        rows  = CW'(r);
        @(negedge clk);
        start = 1'b0;
        while (!finished && cyc < 2000) begin
            outReady = toggleReady ? rdyPhase : 1'b1;
            rdyPhase = ~rdyPhase;
            inValid  = (pixIdx < pixQ.size());
            inData   = inValid ? DW'(pixQ[pixIdx]) : '0;
            start    = pokeStart && (pixIdx > 2) && (pixIdx < 40) && cyc[0];
            #1;
            if (err) errSeen++;
            if (done) begin
                finished = 1'b1;
            end else begin
                if (toggleReady && outValid && !outReady)
                    checkOutput({name, " in_ready while stalled"}, {31'd0, inReady}, 32'd0);
                inAcc = inValid && inReady;
                outHs = outValid && outReady;
                if (outHs) begin
                    if (resCnt < expQ.size())
                        checkOutput($sformatf("%s result %0d", name, resCnt), {16'd0, outData}, 32'(expQ[resCnt]));
                    resCnt++;
                end
                @(posedge clk);
                if (inAcc) pixIdx++;
                cyc++;
                if (abortAfter > 0 && pixIdx == abortAfter) break;
                @(negedge clk);
            end
        end
        start = 1'b0;

        if (abortAfter > 0) begin
            checkOutput({name, " pixels before abort"}, 32'(pixIdx), 32'(abortAfter));
            @(negedge clk);
            rstN = 1'b0;
            @(negedge clk);
            #1;
            checkIdleOutputs({name, " after reset"});
            rstN = 1'b1;
            @(negedge clk);
            #1;
            checkOutput({name, " no consume after reset"}, {31'd0, inReady}, 32'd0);
            inValid = 1'b0;
            return;
        end

        inValid = 1'b0;
        checkOutput({name, " done seen"}, {31'd0, finished}, 32'd1);
        checkOutput({name, " result count"}, 32'(resCnt), 32'(expQ.size()));
        checkOutput({name, " pixels consumed"}, 32'(pixIdx), 32'(pixQ.size()));
        if (pokeStart) checkOutput({name, " no err mid-frame"}, 32'(errSeen), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({name, " done one cycle"}, {31'd0, done}, 32'd0);
        checkOutput({name, " busy after done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstN     = 1'b0;
        start    = 1'b0;
        cols     = '0;
        rows     = '0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        rstN = 1'b1;

        pixQ = '{1, 2, 3, 4, 5, 6};
        expQ = '{12, 16};
        applyStimulus("c3r2", 3, 2, 1'b0, 0, 1'b0);

        pixQ.delete();
        for (int i = 0; i < 12; i++) pixQ.push_back(i);
        expQ = '{10, 14, 18, 26, 30, 34};
        applyStimulus("c4r3 stall", 4, 3, 1'b1, 0, 1'b0);

        pixQ = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        expQ = '{0};
        applyStimulus("wrap", 2, 2, 1'b0, 0, 1'b0);

        checkReject(1, 2);
        checkReject(17, 2);
        checkReject(2, 1);

        pixQ.delete();
        for (int i = 0; i < 12; i++) pixQ.push_back(i);
        expQ.delete();
        applyStimulus("abort", 4, 3, 1'b0, 5, 1'b0);

        pixQ = '{1, 2, 3, 4, 5, 6};
        expQ = '{12, 16};
        applyStimulus("after abort", 3, 2, 1'b0, 0, 1'b0);

        pixQ.delete();
        expQ.delete();
        for (int i = 0; i < 48; i++) pixQ.push_back(1);
        for (int i = 0; i < 30; i++) expQ.push_back(4);
        applyStimulus("c16r3 ones", 16, 3, 1'b0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
